// File: rtl/eth_pkg.sv
// Shared Ethernet TX constants and the preamble-inserter state encoding.
// Imported by txepreamble and its helpers.
// No logic, no latency.
package eth_pkg;

  localparam logic [7:0] ETH_PREAMBLE = 8'h55;
  localparam logic [7:0] ETH_SFD      = 8'hd5;
  localparam int         ETH_PRE_LEN  = 8;
  localparam int         ETH_IFG_DEF  = 12;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_DATA = 3'd2,
    ST_GAP  = 3'd3,
    ST_SKIP = 3'd4
  } state_t;

endpackage

// File: rtl/bytedelay.sv
// Fixed-depth {valid, byte} shift register advanced by a byte strobe.
// Latency: DEPTH ce-cycles from in_* to out_*; out_* is the last stage.
// No backpressure: shifts on every ce, holds when ce is low.
// Ports: clk, rst_n (async active-low), ce, in_v/in_d (stage 0 load),
//        out_v/out_d (tap of the final stage, combinational read).
module bytedelay #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic       in_v,
  input  logic [7:0] in_d,
  output logic       out_v,
  output logic [7:0] out_d
);

  logic [DEPTH-1:0] v_sr;
  logic [7:0]       d_sr [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_sr <= '0;
      for (int i = 0; i < DEPTH; i++) d_sr[i] <= 8'h00;
    end else if (ce) begin
      v_sr[0] <= in_v;
      d_sr[0] <= in_d;
      for (int i = 1; i < DEPTH; i++) begin
        v_sr[i] <= v_sr[i-1];
        d_sr[i] <= d_sr[i-1];
      end
    end
  end

  assign out_v = v_sr[DEPTH-1];
  assign out_d = d_sr[DEPTH-1];

endmodule

// File: rtl/txepreamble.sv
// TX preamble/SFD inserter with inter-frame-gap enforcement; early frames are dropped.
// Latency: 8 ce-cycles input to output; first preamble byte follows the frame-start edge.
// No backpressure: input is consumed every ce; frames arriving inside the gap are discarded.
// Ports: i_clk, i_reset_n (async active-low), i_ce (byte strobe), i_en (preamble enable,
//        sampled at frame start), i_v/i_d (input bytes), o_v/o_d (registered output bytes),
//        o_drop (combinational pulse on the ce-cycle a frame start is discarded).
module txepreamble
  import eth_pkg::*;
#(
  parameter int OPT_IFG = ETH_IFG_DEF
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_ce,
  input  logic       i_en,
  input  logic       i_v,
  input  logic [7:0] i_d,
  output logic       o_v,
  output logic [7:0] o_d,
  output logic       o_drop
);

  localparam int CW = (OPT_IFG > ETH_PRE_LEN) ? $clog2(OPT_IFG) : $clog2(ETH_PRE_LEN);
  localparam logic [CW-1:0] PRE_LAST = CW'(ETH_PRE_LEN - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(OPT_IFG - 1);

  state_t        state, state_nxt;
  state_t        ret, ret_nxt;
  state_t        eff, adv_st, out_st;
  logic [CW-1:0] cnt, cnt_nxt, adv_cnt;
  logic          r_en, r_en_nxt;
  logic          prev_v;
  logic          acc, acc_nxt;
  logic          frame_start, start_ok, drop;
  logic          tap_v;
  logic [7:0]    tap_d;
  logic          out_v_nxt;
  logic [7:0]    out_d_nxt;

  // While skipping a discarded frame, the pending state keeps running underneath.
  assign eff         = (state == ST_SKIP) ? ret : state;
  assign frame_start = i_v & ~prev_v;
  // The last gap cycle already counts as idle, so a frame whose first byte lands
  // exactly at the minimum input gap is accepted.
  assign start_ok    = frame_start &
                       ((eff == ST_IDLE) || ((eff == ST_GAP) && (cnt == GAP_LAST)));
  assign drop        = frame_start & ~start_ok;
  assign o_drop      = i_ce & drop;
  assign acc_nxt     = i_v & (start_ok | acc);

  bytedelay #(
    .DEPTH (ETH_PRE_LEN)
  ) u_delay (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .ce    (i_ce),
    .in_v  (acc_nxt),
    .in_d  (acc_nxt ? i_d : 8'h00),
    .out_v (tap_v),
    .out_d (tap_d)
  );

  // State register; output bytes are registered alongside.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state  <= ST_IDLE;
      ret    <= ST_IDLE;
      cnt    <= '0;
      r_en   <= 1'b0;
      prev_v <= 1'b1;   // a frame in flight at reset release is ignored
      acc    <= 1'b0;
      o_v    <= 1'b0;
      o_d    <= 8'h00;
    end else if (i_ce) begin
      state  <= state_nxt;
      ret    <= ret_nxt;
      cnt    <= cnt_nxt;
      r_en   <= r_en_nxt;
      prev_v <= i_v;
      acc    <= acc_nxt;
      o_v    <= out_v_nxt;
      o_d    <= out_d_nxt;
    end
  end

  // One-step advance of the non-skip state machine.
  always_comb begin
    adv_st  = eff;
    adv_cnt = cnt;
    case (eff)
      ST_IDLE: begin
        adv_st  = ST_IDLE;
        adv_cnt = '0;
      end
      ST_PRE: begin
        if (cnt == PRE_LAST) begin
          adv_st  = ST_DATA;
          adv_cnt = '0;
        end else begin
          adv_cnt = cnt + CW'(1);
        end
      end
      ST_DATA: begin
        if (!tap_v) begin
          adv_st  = ST_GAP;
          adv_cnt = '0;
        end
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          adv_st  = ST_IDLE;
          adv_cnt = '0;
        end else begin
          adv_cnt = cnt + CW'(1);
        end
      end
      default: begin
        adv_st  = ST_IDLE;
        adv_cnt = '0;
      end
    endcase
  end

  // Next-state selection: accept, discard, continue skipping, or plain advance.
  always_comb begin
    state_nxt = state;
    ret_nxt   = ret;
    cnt_nxt   = cnt;
    r_en_nxt  = r_en;
    if (start_ok) begin
      state_nxt = ST_PRE;
      cnt_nxt   = '0;
      r_en_nxt  = i_en;
    end else if (drop) begin
      state_nxt = ST_SKIP;
      ret_nxt   = adv_st;
      cnt_nxt   = adv_cnt;
    end else if (state == ST_SKIP) begin
      cnt_nxt = adv_cnt;
      if (i_v) ret_nxt   = adv_st;
      else     state_nxt = adv_st;
    end else begin
      state_nxt = adv_st;
      cnt_nxt   = adv_cnt;
    end
  end

  // Output byte for the state being entered: preamble while in PRE, else delay tap.
  always_comb begin
    out_st    = (state_nxt == ST_SKIP) ? ret_nxt : state_nxt;
    out_v_nxt = tap_v;
    out_d_nxt = tap_v ? tap_d : 8'h00;
    if (out_st == ST_PRE) begin
      out_v_nxt = r_en_nxt;
      if (!r_en_nxt)               out_d_nxt = 8'h00;
      else if (cnt_nxt == PRE_LAST) out_d_nxt = ETH_SFD;
      else                          out_d_nxt = ETH_PREAMBLE;
    end
  end

endmodule
